instruction_decode: RTL
=======================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have one clock and one reset: clk in 1 (rising edge); arst_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL provide in_valid  in  1, qualifying fetch instruction/PC.
REQ-003 SHALL provide in_instr  in  32, the fetched instruction word.
REQ-004 SHALL provide in_pc  in  32, the PC of in_instr.
REQ-005 SHALL provide in_ready  out  1, meaning the block can accept an entry this cycle.
REQ-006 SHALL provide flush  in  1, a synchronous discard of all held entries (taken branch/jump).
REQ-007 SHALL provide out_valid  out  1 and out_ready  in  1, the downstream handshake.
REQ-008 SHALL provide these field outputs: out_pc 32, opcode 6, rs 5, rt 5, rd 5, shamt 5, funct 6, imm16 16, jtarget 26.
REQ-009 SHALL provide these control outputs, 1 bit each: reg_dst, alu_src, mem_to_reg, reg_wr, mem_wr, branch_eq, branch_ne, jump, ext_op (1 = sign-extend), illegal.
REQ-010 SHALL provide alu_ctr  out  3, with encoding add 000, sub 001, and 010, or 011, slt 100, sltu 101, sll 110.

Function
REQ-011 SHALL store accepted entries {instr, pc} in a 2-entry FIFO and present the oldest entry on the outputs.
REQ-012 SHALL perform a transfer in on in_valid&in_ready and a transfer out on out_valid&out_ready.
REQ-013 SHALL drive in_ready = (count<2) from registered count only, with no combinational path from out_ready.
REQ-014 SHALL give 1-cycle latency: an entry accepted at edge N has out_valid high after edge N when the FIFO was empty.
REQ-015 SHALL, on simultaneous push and pop with count=2, perform the pop only, since in_ready=0 means no push occurs.
REQ-016 SHALL, on simultaneous push and pop with count=1, leave count at 1 with the new entry at the head.
REQ-017 SHALL keep the output entry and all outputs stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, when flush=1 at an edge, set count to 0 and drop any push in that cycle, so out_valid=0 in the next cycle.
REQ-019 SHALL give flush priority over push and pop.
REQ-020 SHALL implement head/tail pointers as 1-bit values wrapping 1->0, with count range 0..2.
REQ-021 SHALL decode fields purely from the head instruction: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0], jtarget=[25:0].
REQ-022 SHALL decode R-type (opcode 00) by funct: 20/21 add, 22/23 sub, 24 and, 25 or, 2A slt, 2B sltu, 00 sll; control reg_dst=1, reg_wr=1, all other controls 0.
REQ-023 SHALL decode addi 08 and addiu 09 as alu add, alu_src=1, reg_wr=1, ext_op=1.
REQ-024 SHALL decode ori 0D as alu or, alu_src=1, reg_wr=1, ext_op=0.
REQ-025 SHALL decode lw 23 as alu add, alu_src=1, mem_to_reg=1, reg_wr=1, ext_op=1.
REQ-026 SHALL decode sw 2B as alu add, alu_src=1, mem_wr=1, ext_op=1.
REQ-027 SHALL decode beq 04 and bne 05 as alu sub, ext_op=1, branch_eq or branch_ne respectively.
REQ-028 SHALL decode j 02 as jump=1.
REQ-029 SHALL treat any other opcode or funct as illegal=1 with all write/branch/jump controls 0.
REQ-030 SHALL force every output except in_ready to 0 while out_valid=0.

Reset
REQ-031 SHALL, on arst_n low, immediately set count=0, set both pointers to 0, and clear all storage.
REQ-032 SHALL hold all outputs at 0 and in_ready=0 during reset.
REQ-033 SHALL drive in_ready=1 on the first clk after arst_n deasserts.
REQ-034 SHALL discard in-flight entries on a mid-operation reset, with no partial outputs.

Structure
REQ-035 SHALL place opcode/funct constants and the alu_ctr encoding in a shared package, isa_pkg, reused by the ALU and control.
REQ-036 SHALL implement decode as one combinational sub-module, control_decode (instr -> controls), instantiated once at the FIFO head.

Verification
REQ-037 SHALL cover: push 0x8C220004 (lw $2,4($1)), pc 0x00400020 -> next cycle out_valid=1, rs=1, rt=2, imm16=0004, alu_ctr=000, alu_src=1, mem_to_reg=1, reg_wr=1.
REQ-038 SHALL cover: push 0x00851020 (add $2,$4,$5) and 0x10A0FFFE (beq) back-to-back, out_ready=0 -> in_ready=0 after 2 pushes, outputs held on add (reg_dst=1, rd=2).
REQ-039 SHALL cover: a full FIFO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, the pushed entry never appears.
REQ-040 SHALL cover: push 0xFC000000 -> illegal=1, reg_wr=0, mem_wr=0, jump=0.
REQ-041 SHALL cover: count=1 with simultaneous push and pop for 10 cycles -> each entry emitted exactly once, in order, out_valid continuously 1.
REQ-042 SHALL cover: assert arst_n=0 asynchronously mid-stream with count=2 -> out_valid and in_ready drop immediately; after release, first output is the next new push.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants: opcode/funct encodings and the ALU control code,
// used by both the control decoder and the ALU.
package isa_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SLL  = 3'b110
  } alu_ctr_e;

endpackage

// File: rtl/control_decode.sv
// Purely combinational main/ALU control decoder: instruction word -> control bits.
module control_decode
  import isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        reg_dst_o,
  output logic        alu_src_o,
  output logic        mem_to_reg_o,
  output logic        reg_wr_o,
  output logic        mem_wr_o,
  output logic        branch_eq_o,
  output logic        branch_ne_o,
  output logic        jump_o,
  output logic        ext_op_o,
  output logic        illegal_o,
  output logic [2:0]  alu_ctr_o
);

  alu_ctr_e   alu;
  logic [5:0] op;
  logic [5:0] fn;

  assign op        = instr_i[31:26];
  assign fn        = instr_i[5:0];
  assign alu_ctr_o = alu;

  always_comb begin
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_wr_o     = 1'b0;
    mem_wr_o     = 1'b0;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    jump_o       = 1'b0;
    ext_op_o     = 1'b0;
    illegal_o    = 1'b0;
    alu          = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        reg_dst_o = 1'b1;
        reg_wr_o  = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: alu = ALU_ADD;
          FN_SUB, FN_SUBU: alu = ALU_SUB;
          FN_AND:          alu = ALU_AND;
          FN_OR:           alu = ALU_OR;
          FN_SLT:          alu = ALU_SLT;
          FN_SLTU:         alu = ALU_SLTU;
          FN_SLL:          alu = ALU_SLL;
          default: begin
            reg_dst_o = 1'b0;
            reg_wr_o  = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_src_o = 1'b1;
        reg_wr_o  = 1'b1;
        ext_op_o  = 1'b1;
      end
      OP_ORI: begin
        alu       = ALU_OR;
        alu_src_o = 1'b1;
        reg_wr_o  = 1'b1;
      end
      OP_LW: begin
        alu_src_o    = 1'b1;
        mem_to_reg_o = 1'b1;
        reg_wr_o     = 1'b1;
        ext_op_o     = 1'b1;
      end
      OP_SW: begin
        alu_src_o = 1'b1;
        mem_wr_o  = 1'b1;
        ext_op_o  = 1'b1;
      end
      OP_BEQ: begin
        alu         = ALU_SUB;
        ext_op_o    = 1'b1;
        branch_eq_o = 1'b1;
      end
      OP_BNE: begin
        alu         = ALU_SUB;
        ext_op_o    = 1'b1;
        branch_ne_o = 1'b1;
      end
      OP_J:    jump_o    = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: 2-entry {instr, pc} FIFO with the head entry's fields and
// controls presented on the outputs, all forced to zero while empty.
module instruction_decode
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jtarget,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_wr,
  output logic        mem_wr,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        jump,
  output logic        ext_op,
  output logic        illegal,
  output logic [2:0]  alu_ctr
);

  logic [31:0] instr_q [2];
  logic [31:0] pc_q    [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        rdy_q;
  logic        push, pop;
  logic [31:0] hd_instr;

  logic c_reg_dst, c_alu_src, c_mem_to_reg, c_reg_wr, c_mem_wr;
  logic c_branch_eq, c_branch_ne, c_jump, c_ext_op, c_illegal;
  logic [2:0] c_alu_ctr;

  // rdy_q holds in_ready low during reset and rises at the first clock after it.
  assign in_ready  = rdy_q & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      rdy_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdy_q   <= 1'b1;
      if (push && !flush) begin
        instr_q[tail_q] <= in_instr;
        pc_q[tail_q]    <= in_pc;
      end
    end
  end

  assign hd_instr = out_valid ? instr_q[head_q] : '0;
  assign out_pc   = out_valid ? pc_q[head_q]    : '0;

  assign opcode  = hd_instr[31:26];
  assign rs      = hd_instr[25:21];
  assign rt      = hd_instr[20:16];
  assign rd      = hd_instr[15:11];
  assign shamt   = hd_instr[10:6];
  assign funct   = hd_instr[5:0];
  assign imm16   = hd_instr[15:0];
  assign jtarget = hd_instr[25:0];

  control_decode u_ctrl (
    .instr_i      (hd_instr),
    .reg_dst_o    (c_reg_dst),
    .alu_src_o    (c_alu_src),
    .mem_to_reg_o (c_mem_to_reg),
    .reg_wr_o     (c_reg_wr),
    .mem_wr_o     (c_mem_wr),
    .branch_eq_o  (c_branch_eq),
    .branch_ne_o  (c_branch_ne),
    .jump_o       (c_jump),
    .ext_op_o     (c_ext_op),
    .illegal_o    (c_illegal),
    .alu_ctr_o    (c_alu_ctr)
  );

  // A zero word decodes as sll, so controls need explicit gating when empty.
  assign reg_dst    = out_valid & c_reg_dst;
  assign alu_src    = out_valid & c_alu_src;
  assign mem_to_reg = out_valid & c_mem_to_reg;
  assign reg_wr     = out_valid & c_reg_wr;
  assign mem_wr     = out_valid & c_mem_wr;
  assign branch_eq  = out_valid & c_branch_eq;
  assign branch_ne  = out_valid & c_branch_ne;
  assign jump       = out_valid & c_jump;
  assign ext_op     = out_valid & c_ext_op;
  assign illegal    = out_valid & c_illegal;
  assign alu_ctr    = out_valid ? c_alu_ctr : 3'b000;

endmodule
